// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-client memory arbiter.
//   mem_cmd_t    memory command encoding (NONE / LOAD / STORE)
//   client_id_t  client identity (instruction cache = 0, data cache = 1)
//   blk_t, mem_idx_t, mem_tag_t  default-width data, index and tag types
package mem_arbiter_pkg;

  localparam int MEM_BLK_W = 64;
  localparam int MEM_IDX_W = 29;
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    MEM_CMD_NONE  = 2'd0,
    MEM_CMD_LOAD  = 2'd1,
    MEM_CMD_STORE = 2'd2
  } mem_cmd_t;

  typedef logic [MEM_BLK_W-1:0] blk_t;
  typedef logic [MEM_IDX_W-1:0] mem_idx_t;
  typedef logic [MEM_TAG_W-1:0] mem_tag_t;

  typedef enum logic {
    CL_ICACHE = 1'b0,
    CL_DCACHE = 1'b1
  } client_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // The client that is not 'c'; used for round-robin and back-to-back grants.
  function automatic client_id_t other_client(input client_id_t c);
    return (c == CL_ICACHE) ? CL_DCACHE : CL_ICACHE;
  endfunction

endpackage

// File: rtl/mem_tag_table.sv
// mem_tag_table: remembers which client owns each outstanding load tag.
//   clock, reset         clock and synchronous active-high reset (all entries invalid)
//   set_en/set_tag/set_owner  record {valid, owner} for an acknowledged load
//   rd_tag               tag of the answer currently presented by memory
//   rd_valid/rd_owner    combinational lookup of that tag (pre-edge contents)
//   clr_en               invalidate rd_tag at the edge (answer consumed)
// The lookup always sees the old contents; if set and clear hit the same
// entry in one cycle, the set wins so the new owner survives.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_W = MEM_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  client_id_t       set_owner,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic             clr_en,
  output logic             rd_valid,
  output client_id_t       rd_owner
);

  localparam int DEPTH = 1 << TAG_W;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] owner_q, owner_d;
  logic [DEPTH-1:0] hit_set, hit_clr;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign hit_set[gi] = set_en && (set_tag == TAG_W'(gi));
      assign hit_clr[gi] = clr_en && (rd_tag == TAG_W'(gi));
    end
  endgenerate

  // Clear first, then set, so a same-cycle set overrides the clear.
  assign valid_d = (valid_q & ~hit_clr) | hit_set;
  assign owner_d = (owner_q & ~hit_set) | (hit_set & {DEPTH{set_owner == CL_DCACHE}});

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign rd_valid = valid_q[rd_tag];
  assign rd_owner = owner_q[rd_tag] ? CL_DCACHE : CL_ICACHE;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction cache (client 0)
// and the data cache (client 1).
//   clock, reset                   clock and synchronous active-high reset
//   cl_qry_cmd/idx/blk [2]         per-client request, held until that client's cl_ack != 0
//   cl_ack [2]                     per-client acknowledge tag (0 = none)
//   cl_ans_tag/blk [2]             per-client answer tag and data (0 = none)
//   mem_qry_cmd/idx/blk            registered request presented to memory
//   mem_ack                        memory accept tag (0 = not accepted)
//   mem_ans_tag/blk                memory answer tag and data
// One request is captured at a time and held until memory acknowledges it.
// Load tags are recorded with their owner so answers can be routed back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BLK_W = MEM_BLK_W,
  parameter int IDX_W = MEM_IDX_W,
  parameter int TAG_W = MEM_TAG_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0][1:0]       cl_qry_cmd,
  input  logic [1:0][IDX_W-1:0] cl_qry_idx,
  input  logic [1:0][BLK_W-1:0] cl_qry_blk,
  output logic [1:0][TAG_W-1:0] cl_ack,
  output logic [1:0][TAG_W-1:0] cl_ans_tag,
  output logic [1:0][BLK_W-1:0] cl_ans_blk,
  output logic [1:0]            mem_qry_cmd,
  output logic [IDX_W-1:0]      mem_qry_idx,
  output logic [BLK_W-1:0]      mem_qry_blk,
  input  logic [TAG_W-1:0]      mem_ack,
  input  logic [TAG_W-1:0]      mem_ans_tag,
  input  logic [BLK_W-1:0]      mem_ans_blk
);

  arb_state_t       state_q, state_d;
  client_id_t       owner_q, owner_d;
  client_id_t       last_grant_q, last_grant_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;

  logic [1:0] req;
  logic       grant_en;
  client_id_t grant_id;
  logic       set_en;
  logic       rd_valid;
  client_id_t rd_owner;
  logic       ans_hit;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req[gi] = (cl_qry_cmd[gi] != MEM_CMD_NONE);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    idx_d        = idx_q;
    blk_d        = blk_q;
    grant_en     = 1'b0;
    grant_id     = CL_ICACHE;
    set_en       = 1'b0;
    cl_ack       = '0;

    unique case (state_q)
      ST_IDLE: begin
        // mem_ack is ignored here; only new requests matter.
        if (|req) begin
          grant_en = 1'b1;
          if (&req) grant_id = other_client(last_grant_q);
          else      grant_id = req[1] ? CL_DCACHE : CL_ICACHE;
        end
      end
      ST_BUSY: begin
        if (mem_ack != '0) begin
          cl_ack[owner_q] = mem_ack;
          set_en          = (cmd_q == MEM_CMD_LOAD);
          // The acked client still holds its request this cycle, so only
          // the other client may be granted (back-to-back, no idle cycle).
          if (req[other_client(owner_q)]) begin
            grant_en = 1'b1;
            grant_id = other_client(owner_q);
          end else begin
            state_d = ST_IDLE;
            cmd_d   = MEM_CMD_NONE;
            idx_d   = '0;
            blk_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_en) begin
      state_d      = ST_BUSY;
      owner_d      = grant_id;
      last_grant_d = grant_id;
      cmd_d        = mem_cmd_t'(cl_qry_cmd[grant_id]);
      idx_d        = cl_qry_idx[grant_id];
      blk_d        = cl_qry_blk[grant_id];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= CL_ICACHE;
      last_grant_q <= CL_DCACHE;
      cmd_q        <= MEM_CMD_NONE;
      idx_q        <= '0;
      blk_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      idx_q        <= idx_d;
      blk_q        <= blk_d;
    end
  end

  assign mem_qry_cmd = cmd_q;
  assign mem_qry_idx = idx_q;
  assign mem_qry_blk = blk_q;

  mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
    .clock     (clock),
    .reset     (reset),
    .set_en    (set_en),
    .set_tag   (mem_ack),
    .set_owner (owner_q),
    .rd_tag    (mem_ans_tag),
    .clr_en    (ans_hit),
    .rd_valid  (rd_valid),
    .rd_owner  (rd_owner)
  );

  // Answer routing does not depend on the FSM state; unknown tags are dropped.
  assign ans_hit = (mem_ans_tag != '0) && rd_valid;

  always_comb begin
    cl_ans_tag = '0;
    cl_ans_blk = '0;
    if (ans_hit) begin
      cl_ans_tag[rd_owner] = mem_ans_tag;
      cl_ans_blk[rd_owner] = mem_ans_blk;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int BW = 64;
  localparam int IW = 29;
  localparam int TW = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic [1:0][1:0]    cl_qry_cmd;
  logic [1:0][IW-1:0] cl_qry_idx;
  logic [1:0][BW-1:0] cl_qry_blk;
  logic [1:0][TW-1:0] cl_ack;
  logic [1:0][TW-1:0] cl_ans_tag;
  logic [1:0][BW-1:0] cl_ans_blk;
  logic [1:0]         mem_qry_cmd;
  logic [IW-1:0]      mem_qry_idx;
  logic [BW-1:0]      mem_qry_blk;
  logic [TW-1:0]      mem_ack;
  logic [TW-1:0]      mem_ans_tag;
  logic [BW-1:0]      mem_ans_blk;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.BLK_W(BW), .IDX_W(IW), .TAG_W(TW)) dut (
    .clock       (clock),
    .reset       (reset),
    .cl_qry_cmd  (cl_qry_cmd),
    .cl_qry_idx  (cl_qry_idx),
    .cl_qry_blk  (cl_qry_blk),
    .cl_ack      (cl_ack),
    .cl_ans_tag  (cl_ans_tag),
    .cl_ans_blk  (cl_ans_blk),
    .mem_qry_cmd (mem_qry_cmd),
    .mem_qry_idx (mem_qry_idx),
    .mem_qry_blk (mem_qry_blk),
    .mem_ack     (mem_ack),
    .mem_ans_tag (mem_ans_tag),
    .mem_ans_blk (mem_ans_blk)
  );

  // ---------------- reference model (transaction level) ----------------
  bit                 m_busy;
  int                 m_owner;
  int                 m_last;
  logic [1:0]         m_cmd;
  logic [IW-1:0]      m_idx;
  logic [BW-1:0]      m_blk;
  bit                 m_valid [16];
  int                 m_own   [16];
  logic [1:0][TW-1:0] e_ack;
  logic [1:0][TW-1:0] e_ans_tag;
  logic [1:0][BW-1:0] e_ans_blk;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1;
    m_cmd = '0; m_idx = '0; m_blk = '0;
    for (int t = 0; t < 16; t++) begin m_valid[t] = 0; m_own[t] = 0; end
  endtask

  task automatic model_grant(input int g);
    m_busy = 1; m_owner = g; m_last = g;
    m_cmd = cl_qry_cmd[g]; m_idx = cl_qry_idx[g]; m_blk = cl_qry_blk[g];
  endtask

  task automatic model_outputs();
    e_ack = '0; e_ans_tag = '0; e_ans_blk = '0;
    if (m_busy && mem_ack != 0) e_ack[m_owner] = mem_ack;
    if (mem_ans_tag != 0 && m_valid[mem_ans_tag]) begin
      e_ans_tag[m_own[mem_ans_tag]] = mem_ans_tag;
      e_ans_blk[m_own[mem_ans_tag]] = mem_ans_blk;
    end
  endtask

  task automatic model_commit();
    bit acked;
    if (reset) begin model_reset(); return; end
    acked = m_busy && (mem_ack != 0);
    if (mem_ans_tag != 0 && m_valid[mem_ans_tag]) m_valid[mem_ans_tag] = 0;
    if (acked) begin
      if (m_cmd == MEM_CMD_LOAD) begin
        m_valid[mem_ack] = 1;
        m_own[mem_ack]   = m_owner;
      end
      if (cl_qry_cmd[1-m_owner] != MEM_CMD_NONE) model_grant(1 - m_owner);
      else begin m_busy = 0; m_cmd = '0; m_idx = '0; m_blk = '0; end
    end else if (!m_busy) begin
      if (cl_qry_cmd[0] != MEM_CMD_NONE && cl_qry_cmd[1] != MEM_CMD_NONE) model_grant(1 - m_last);
      else if (cl_qry_cmd[0] != MEM_CMD_NONE) model_grant(0);
      else if (cl_qry_cmd[1] != MEM_CMD_NONE) model_grant(1);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    cl_qry_cmd = '0; cl_qry_idx = '0; cl_qry_blk = '0;
    mem_ack = '0; mem_ans_tag = '0; mem_ans_blk = '0;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    clr_in();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (mem_qry_cmd !== 2'd0) begin errors++; $display("FAIL reset_cmd got %h want 0", mem_qry_cmd); end
    checks++; if (mem_qry_idx !== '0) begin errors++; $display("FAIL reset_idx got %h want 0", mem_qry_idx); end
    checks++; if (mem_qry_blk !== '0) begin errors++; $display("FAIL reset_blk got %h want 0", mem_qry_blk); end
    checks++; if (cl_ack !== '0 || cl_ans_tag !== '0 || cl_ans_blk !== '0) begin
      errors++; $display("FAIL reset_cl ack %h tag %h blk %h want all 0", cl_ack, cl_ans_tag, cl_ans_blk);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_load();
    tick();
    cl_qry_cmd[1] = MEM_CMD_LOAD; cl_qry_idx[1] = 29'd2;
    tick(); #1;
    checks++; if (mem_qry_cmd !== MEM_CMD_LOAD || mem_qry_idx !== 29'd2) begin
      errors++; $display("FAIL load_issue cmd %h idx %h want 1/2", mem_qry_cmd, mem_qry_idx);
    end
    tick(); #1;
    checks++; if (cl_ack !== '0 || mem_qry_idx !== 29'd2) begin
      errors++; $display("FAIL load_wait ack %h idx %h want 00/2", cl_ack, mem_qry_idx);
    end
    mem_ack = 4'd3; #1;
    checks++; if (cl_ack !== 8'h30) begin errors++; $display("FAIL load_ack got %h want 30", cl_ack); end
    tick();
    cl_qry_cmd[1] = MEM_CMD_NONE; mem_ack = '0; #1;
    checks++; if (mem_qry_cmd !== MEM_CMD_NONE) begin errors++; $display("FAIL load_idle got %h want 0", mem_qry_cmd); end
    mem_ans_tag = 4'd3; mem_ans_blk = 64'hdeadbeefcc00ffee; #1;
    checks++; if (cl_ans_tag !== 8'h30 || cl_ans_blk[1] !== 64'hdeadbeefcc00ffee || cl_ans_blk[0] !== '0) begin
      errors++; $display("FAIL load_ans tag %h blk1 %h blk0 %h want 30/deadbeefcc00ffee/0", cl_ans_tag, cl_ans_blk[1], cl_ans_blk[0]);
    end
    tick(); #1;
    checks++; if (cl_ans_tag !== '0) begin errors++; $display("FAIL load_ans_cleared got %h want 00", cl_ans_tag); end
    clr_in();
    $display("test_single_load done");
  endtask

  task automatic test_simultaneous();
    clr_in(); reset = 1'b1; tick(); reset = 1'b0;
    cl_qry_cmd[0] = MEM_CMD_LOAD; cl_qry_idx[0] = 29'd5;
    cl_qry_cmd[1] = MEM_CMD_LOAD; cl_qry_idx[1] = 29'd9;
    tick(); #1;
    checks++; if (mem_qry_cmd !== MEM_CMD_LOAD || mem_qry_idx !== 29'd5) begin
      errors++; $display("FAIL rr_first cmd %h idx %h want 1/5", mem_qry_cmd, mem_qry_idx);
    end
    mem_ack = 4'd1; #1;
    checks++; if (cl_ack !== 8'h01) begin errors++; $display("FAIL rr_ack0 got %h want 01", cl_ack); end
    tick();
    cl_qry_cmd[0] = MEM_CMD_NONE; mem_ack = '0; #1;
    checks++; if (mem_qry_cmd !== MEM_CMD_LOAD || mem_qry_idx !== 29'd9) begin
      errors++; $display("FAIL rr_b2b cmd %h idx %h want 1/9", mem_qry_cmd, mem_qry_idx);
    end
    mem_ack = 4'd2; #1;
    checks++; if (cl_ack !== 8'h20) begin errors++; $display("FAIL rr_ack1 got %h want 20", cl_ack); end
    tick();
    cl_qry_cmd[1] = MEM_CMD_NONE; mem_ack = '0;
    mem_ans_tag = 4'd2; mem_ans_blk = 64'h22; #1;
    checks++; if (cl_ans_tag !== 8'h20 || cl_ans_blk[1] !== 64'h22) begin
      errors++; $display("FAIL rr_ans2 tag %h blk1 %h want 20/22", cl_ans_tag, cl_ans_blk[1]);
    end
    tick();
    mem_ans_tag = 4'd1; mem_ans_blk = 64'h11; #1;
    checks++; if (cl_ans_tag !== 8'h01 || cl_ans_blk[0] !== 64'h11) begin
      errors++; $display("FAIL rr_ans1 tag %h blk0 %h want 01/11", cl_ans_tag, cl_ans_blk[0]);
    end
    tick(); clr_in();
    $display("test_simultaneous done");
  endtask

  task automatic test_store();
    cl_qry_cmd[1] = MEM_CMD_STORE; cl_qry_idx[1] = 29'd7; cl_qry_blk[1] = 64'h1234;
    tick(); #1;
    checks++; if (mem_qry_cmd !== MEM_CMD_STORE || mem_qry_idx !== 29'd7 || mem_qry_blk !== 64'h1234) begin
      errors++; $display("FAIL store_issue cmd %h idx %h blk %h want 2/7/1234", mem_qry_cmd, mem_qry_idx, mem_qry_blk);
    end
    mem_ack = 4'd4; #1;
    checks++; if (cl_ack !== 8'h40) begin errors++; $display("FAIL store_ack got %h want 40", cl_ack); end
    tick(); clr_in(); tick();
    mem_ans_tag = 4'd4; mem_ans_blk = 64'h4444; #1;
    checks++; if (cl_ans_tag !== '0 || cl_ans_blk !== '0) begin
      errors++; $display("FAIL store_no_ans tag %h blk %h want 0", cl_ans_tag, cl_ans_blk);
    end
    tick(); clr_in();
    $display("test_store done");
  endtask

  task automatic test_same_tag();
    cl_qry_cmd[0] = MEM_CMD_LOAD; cl_qry_idx[0] = 29'd11;
    tick();
    mem_ack = 4'd5; #1;
    checks++; if (cl_ack !== 8'h05) begin errors++; $display("FAIL same_ack0 got %h want 05", cl_ack); end
    tick();
    cl_qry_cmd[0] = MEM_CMD_NONE; mem_ack = '0;
    cl_qry_cmd[1] = MEM_CMD_LOAD; cl_qry_idx[1] = 29'd12;
    tick();
    mem_ack = 4'd5; mem_ans_tag = 4'd5; mem_ans_blk = 64'h55; #1;
    checks++; if (cl_ack !== 8'h50 || cl_ans_tag !== 8'h05 || cl_ans_blk[0] !== 64'h55 || cl_ans_blk[1] !== '0) begin
      errors++; $display("FAIL same_old ack %h tag %h blk0 %h blk1 %h want 50/05/55/0", cl_ack, cl_ans_tag, cl_ans_blk[0], cl_ans_blk[1]);
    end
    tick();
    cl_qry_cmd[1] = MEM_CMD_NONE; mem_ack = '0; mem_ans_tag = 4'd5; mem_ans_blk = 64'h66; #1;
    checks++; if (cl_ans_tag !== 8'h50 || cl_ans_blk[1] !== 64'h66 || cl_ans_blk[0] !== '0) begin
      errors++; $display("FAIL same_new tag %h blk1 %h blk0 %h want 50/66/0", cl_ans_tag, cl_ans_blk[1], cl_ans_blk[0]);
    end
    tick(); clr_in();
    $display("test_same_tag done");
  endtask

  task automatic test_reset_busy();
    cl_qry_cmd[0] = MEM_CMD_LOAD; cl_qry_idx[0] = 29'd3;
    tick();
    mem_ack = 4'd6;
    tick();
    cl_qry_cmd[0] = MEM_CMD_NONE; mem_ack = '0;
    cl_qry_cmd[1] = MEM_CMD_LOAD; cl_qry_idx[1] = 29'd4;
    tick();
    mem_ack = 4'd7; reset = 1'b1;
    tick();
    reset = 1'b0; cl_qry_cmd[1] = MEM_CMD_NONE; #1;
    checks++; if (mem_qry_cmd !== MEM_CMD_NONE || mem_qry_idx !== '0 || cl_ack !== '0) begin
      errors++; $display("FAIL rst_busy cmd %h idx %h ack %h want 0/0/0", mem_qry_cmd, mem_qry_idx, cl_ack);
    end
    tick();
    mem_ack = '0; mem_ans_tag = 4'd6; mem_ans_blk = 64'hff; #1;
    checks++; if (cl_ans_tag !== '0 || cl_ans_blk !== '0) begin
      errors++; $display("FAIL rst_stale tag %h blk %h want 0", cl_ans_tag, cl_ans_blk);
    end
    tick(); clr_in();
    $display("test_reset_busy done");
  endtask

  task automatic test_orphan();
    clr_in(); reset = 1'b1; tick(); reset = 1'b0;
    mem_ans_tag = 4'd9; mem_ans_blk = 64'h9999; #1;
    checks++; if (cl_ans_tag !== '0 || cl_ans_blk !== '0) begin
      errors++; $display("FAIL orphan tag %h blk %h want 0", cl_ans_tag, cl_ans_blk);
    end
    tick(); clr_in();
    $display("test_orphan done");
  endtask

  // ---------------- randomized test against the model ----------------
  task automatic test_random();
    bit ack_seen [2];
    int t, start;
    clr_in(); reset = 1'b1;
    @(posedge clock); model_commit(); #1;
    reset = 1'b0;
    ack_seen[0] = 0; ack_seen[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (ack_seen[i]) cl_qry_cmd[i] = MEM_CMD_NONE;
        if (cl_qry_cmd[i] == MEM_CMD_NONE && $urandom_range(0, 2) == 0) begin
          cl_qry_cmd[i] = ($urandom_range(0, 1) == 0) ? MEM_CMD_LOAD : MEM_CMD_STORE;
          cl_qry_idx[i] = IW'($urandom);
          cl_qry_blk[i] = {$urandom, $urandom};
        end
      end
      mem_ack = '0;
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 8; k++) begin
          t = $urandom_range(1, 15);
          if (!m_valid[t]) begin mem_ack = TW'(t); break; end
        end
      end
      mem_ans_tag = '0;
      mem_ans_blk = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: mem_ans_tag = TW'($urandom_range(0, 15));
        1: begin
          start = $urandom_range(0, 15);
          for (int k = 0; k < 16; k++) begin
            t = (start + k) % 16;
            if (t != 0 && m_valid[t]) begin mem_ans_tag = TW'(t); break; end
          end
        end
        default: ;
      endcase
      #1;
      model_outputs();
      @(negedge clock);
      checks++; if (cl_ack !== e_ack) begin errors++; $display("FAIL rnd_ack cyc %0d got %h want %h", cyc, cl_ack, e_ack); end
      checks++; if (cl_ans_tag !== e_ans_tag) begin errors++; $display("FAIL rnd_ans_tag cyc %0d got %h want %h", cyc, cl_ans_tag, e_ans_tag); end
      checks++; if (cl_ans_blk !== e_ans_blk) begin errors++; $display("FAIL rnd_ans_blk cyc %0d got %h want %h", cyc, cl_ans_blk, e_ans_blk); end
      checks++; if (mem_qry_cmd !== m_cmd) begin errors++; $display("FAIL rnd_cmd cyc %0d got %h want %h", cyc, mem_qry_cmd, m_cmd); end
      checks++; if (mem_qry_idx !== m_idx) begin errors++; $display("FAIL rnd_idx cyc %0d got %h want %h", cyc, mem_qry_idx, m_idx); end
      checks++; if (mem_qry_blk !== m_blk) begin errors++; $display("FAIL rnd_blk cyc %0d got %h want %h", cyc, mem_qry_blk, m_blk); end
      ack_seen[0] = (e_ack[0] != 0);
      ack_seen[1] = (e_ack[1] != 0);
      @(posedge clock);
      model_commit();
      #1;
    end
    clr_in();
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    test_reset();
    test_single_load();
    test_simultaneous();
    test_store();
    test_same_tag();
    test_reset_busy();
    test_orphan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
